// File: rtl/mdu_req_arbiter.sv
// ---------------------------------------------------------------------------
// mdu_req_arbiter
//
// Shares one fixed-latency pipelined multiplier among NUM_REQ requesters.
// A round-robin arbiter issues at most one op per cycle. The issue is
// zero-cycle: the accept and the multiplier strobe happen in the same cycle.
// A tag pipe records which requester owns each in-flight op, so each result
// is steered back to its requester. Each requester may have only one op
// outstanding. The block also drives the multiplier clear on flush.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   flush        cancels every pending and in-flight op
//   req_vld      per-requester request valid
//   req_ready    per-requester accept (one-hot grant)
//   req_a/req_b  packed operands, requester i at [32*i +: 32]
//   rsp_vld      one-hot result strobe (single-cycle, no backpressure)
//   rsp_data     result shared by all requesters, 0 when no strobe
//   mul_srcA/B   operands to the multiplier
//   mul_vld      multiplier issue strobe
//   mul_clear    multiplier pipeline clear
//   mul_res      multiplier result
//   mul_res_vld  multiplier result valid
//   busy         any op outstanding
//   err          sticky: result valid did not match the expected tag
// ---------------------------------------------------------------------------
module mdu_req_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int MUL_LATENCY = 2,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_vld,
  output logic [31:0]           rsp_data,
  output logic [31:0]           mul_srcA,
  output logic [31:0]           mul_srcB,
  output logic                  mul_vld,
  output logic                  mul_clear,
  input  logic [31:0]           mul_res,
  input  logic                  mul_res_vld,
  output logic                  busy,
  output logic                  err
);

  localparam int LAST = MUL_LATENCY - 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  logic [ID_W-1:0]        last_grant_q, last_grant_d;
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]        tag_id_q [MUL_LATENCY];
  logic [ID_W-1:0]        tag_id_d [MUL_LATENCY];
  logic                   err_q, err_d;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] eligible;
  logic               arb_en;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;

  // Outputs are forced to their reset values while rst is held, because
  // eligibility is combinational from req_vld and would otherwise leak a grant.
  assign arb_en   = ~flush & ~rst;
  assign eligible = req_vld & ~pending_q;

  // First eligible index after last_grant_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = last_grant_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (!arb_en) begin
      grant_vld = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_vld & (grant_id == ID_W'(gi));
    end
  endgenerate

  // The grant is one-hot, so an AND-OR mux is enough; no grant gives zeros.
  always_comb begin
    mul_srcA = '0;
    mul_srcB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_srcA = req_a[32*i +: 32];
        mul_srcB = req_b[32*i +: 32];
      end
    end
  end

  assign mul_vld   = grant_vld;
  assign mul_clear = flush & ~rst;

  // -------------------------------------------------------------------------
  // Tag pipe: stage 0 captures the issue, the last stage lines up with the
  // multiplier result. A flush invalidates every stage on the next edge.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < MUL_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_vld_d[gi] = grant_vld & ~flush;
        assign tag_id_d[gi]  = grant_vld ? grant_id : '0;
      end else begin : g_body
        assign tag_vld_d[gi] = tag_vld_q[gi-1] & ~flush;
        assign tag_id_d[gi]  = tag_id_q[gi-1];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Response steering
  // -------------------------------------------------------------------------
  logic            rsp_fire;
  logic [ID_W-1:0] rsp_id;

  // A valid result without a matching tag (or the reverse) never fires.
  assign rsp_fire = mul_res_vld & tag_vld_q[LAST] & ~flush & ~rst;
  assign rsp_id   = tag_id_q[LAST];
  assign rsp_data = rsp_fire ? mul_res : 32'd0;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_vld[gi] = rsp_fire & (rsp_id == ID_W'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    // A response for one requester and an accept for another may share an
    // edge; they touch different bits so both take effect.
    if (rsp_fire) begin
      pending_d[rsp_id] = 1'b0;
    end
    if (grant_vld) begin
      pending_d[grant_id] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
    end
  end

  assign last_grant_d = grant_vld ? grant_id : last_grant_q;

  // The multiplier is being cleared during a flush, so its result valid
  // carries no information that cycle and is not checked.
  assign err_d = err_q | (~flush & (mul_res_vld ^ tag_vld_q[LAST]));

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      tag_vld_q    <= '0;
      err_q        <= 1'b0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      tag_vld_q    <= tag_vld_d;
      err_q        <= err_d;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_id_q[s] <= tag_id_d[s];
      end
    end
  end

  assign busy = |pending_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mdu_req_arbiter.sv
module tb_mdu_req_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [NR-1:0] req_vld;
  logic [NR-1:0] req_ready;
  logic [127:0]  req_a, req_b;
  logic [NR-1:0] rsp_vld;
  logic [31:0]   rsp_data;
  logic [31:0]   mul_srcA, mul_srcB;
  logic          mul_vld, mul_clear;
  logic [31:0]   mul_res;
  logic          mul_res_vld;
  logic          busy, err;
  logic          force_vld;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu_req_arbiter #(.NUM_REQ(NR), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_vld(req_vld), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .mul_srcA(mul_srcA), .mul_srcB(mul_srcB),
    .mul_vld(mul_vld), .mul_clear(mul_clear),
    .mul_res(mul_res), .mul_res_vld(mul_res_vld),
    .busy(busy), .err(err)
  );

  // Behavioural multiplier: fixed latency LAT, cleared by mul_clear, reset by rst.
  logic [31:0]    m_data_q [LAT];
  logic [LAT-1:0] m_vld_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_q <= '0;
      for (int i = 0; i < LAT; i++) m_data_q[i] <= '0;
    end else begin
      m_vld_q[0]  <= mul_vld & ~mul_clear;
      m_data_q[0] <= mul_srcA * mul_srcB;
      for (int i = 1; i < LAT; i++) begin
        m_vld_q[i]  <= m_vld_q[i-1] & ~mul_clear;
        m_data_q[i] <= m_data_q[i-1];
      end
    end
  end
  assign mul_res_vld = m_vld_q[LAT-1] | force_vld;
  assign mul_res     = m_vld_q[LAT-1] ? m_data_q[LAT-1] : 32'd0;

  typedef struct {
    logic          rb;
    logic [NR-1:0] vld;
    logic [127:0]  a;
    logic [127:0]  b;
    logic          fl;
    logic [NR-1:0] e_rdy;
    logic          e_mv;
    logic [31:0]   e_sa;
    logic [31:0]   e_sb;
    logic [NR-1:0] e_rsp;
    logic [31:0]   e_data;
    logic          e_busy;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] pk(int x0, int x1, int x2, int x3);
    return {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
  endfunction

  function automatic vec_t mk(logic rb, logic [NR-1:0] vld, logic [127:0] a,
                              logic [127:0] b, logic fl, logic [NR-1:0] rdy,
                              logic mv, int sa, int sb, logic [NR-1:0] rsp,
                              int data, logic bsy, logic er);
    vec_t v;
    v.rb = rb; v.vld = vld; v.a = a; v.b = b; v.fl = fl;
    v.e_rdy = rdy; v.e_mv = mv; v.e_sa = 32'(sa); v.e_sb = 32'(sb);
    v.e_rsp = rsp; v.e_data = 32'(data); v.e_busy = bsy; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; flush = 1'b0; force_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [127:0] ra, rb_, sa, sb_, oa, ob, fa, fb;

  initial begin
    // Round-robin: A=i+1, B=10, all requesters always valid.
    ra = pk(1, 2, 3, 4); rb_ = pk(10, 10, 10, 10);
    vecs.push_back(mk(1, 4'b1111, ra, rb_, 0, 4'b0001, 1, 1, 10, 4'b0000,  0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, ra, rb_, 0, 4'b0010, 1, 2, 10, 4'b0000,  0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, ra, rb_, 0, 4'b0100, 1, 3, 10, 4'b0001, 10, 1, 0));
    vecs.push_back(mk(0, 4'b1111, ra, rb_, 0, 4'b1000, 1, 4, 10, 4'b0010, 20, 1, 0));
    vecs.push_back(mk(0, 4'b1111, ra, rb_, 0, 4'b0001, 1, 1, 10, 4'b0100, 30, 1, 0));
    vecs.push_back(mk(0, 4'b1111, ra, rb_, 0, 4'b0010, 1, 2, 10, 4'b1000, 40, 1, 0));
    vecs.push_back(mk(0, 4'b0000, ra, rb_, 0, 4'b0000, 0, 0,  0, 4'b0001, 10, 1, 0));
    vecs.push_back(mk(0, 4'b0000, ra, rb_, 0, 4'b0000, 0, 0,  0, 4'b0010, 20, 1, 0));
    vecs.push_back(mk(0, 4'b0000, ra, rb_, 0, 4'b0000, 0, 0,  0, 4'b0000,  0, 0, 0));
    // Single op: req0 7*6.
    sa = pk(7, 0, 0, 0); sb_ = pk(6, 0, 0, 0);
    vecs.push_back(mk(1, 4'b0001, sa, sb_, 0, 4'b0001, 1, 7, 6, 4'b0000,  0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, sa, sb_, 0, 4'b0000, 0, 0, 0, 4'b0000,  0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, sa, sb_, 0, 4'b0000, 0, 0, 0, 4'b0001, 42, 1, 0));
    vecs.push_back(mk(0, 4'b0000, sa, sb_, 0, 4'b0000, 0, 0, 0, 4'b0000,  0, 0, 0));
    // Outstanding limit: req1 only, 3*3, reissue every third cycle.
    oa = pk(0, 3, 0, 0); ob = pk(0, 3, 0, 0);
    vecs.push_back(mk(1, 4'b0010, oa, ob, 0, 4'b0010, 1, 3, 3, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0010, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0010, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0010, 9, 1, 0));
    vecs.push_back(mk(0, 4'b0010, oa, ob, 0, 4'b0010, 1, 3, 3, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0010, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0010, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0010, 9, 1, 0));
    vecs.push_back(mk(0, 4'b0010, oa, ob, 0, 4'b0010, 1, 3, 3, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0010, 9, 1, 0));
    vecs.push_back(mk(0, 4'b0000, oa, ob, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    // Flush: req0 then req2 issued, flush in the third cycle.
    fa = pk(5, 0, 4, 0); fb = pk(2, 0, 3, 0);
    vecs.push_back(mk(1, 4'b0101, fa, fb, 0, 4'b0001, 1, 5, 2, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0101, fa, fb, 0, 4'b0100, 1, 4, 3, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1010, fa, fb, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, fa, fb, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, fa, fb, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));

    // Reset state, with requests already presented.
    rst = 1'b1; flush = 1'b0; force_vld = 1'b0;
    req_vld = 4'b1111; req_a = ra; req_b = rb_;
    #12;
    chk("reset.ready",  32'(req_ready), 32'd0);
    chk("reset.mulvld", 32'(mul_vld),   32'd0);
    chk("reset.rsp",    32'(rsp_vld),   32'd0);
    chk("reset.busy",   32'(busy),      32'd0);
    chk("reset.err",    32'(err),       32'd0);
    chk("reset.clear",  32'(mul_clear), 32'd0);
    $display("reset: ready=%b busy=%b err=%b", req_ready, busy, err);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rb) do_reset();
      req_vld = vecs[i].vld; req_a = vecs[i].a; req_b = vecs[i].b; flush = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d.ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.mulvld", i), 32'(mul_vld), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d.srcA", i), mul_srcA, vecs[i].e_sa);
      chk($sformatf("v%0d.srcB", i), mul_srcB, vecs[i].e_sb);
      chk($sformatf("v%0d.rsp", i), 32'(rsp_vld), 32'(vecs[i].e_rsp));
      chk($sformatf("v%0d.data", i), rsp_data, vecs[i].e_data);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d.clear", i), 32'(mul_clear), 32'(vecs[i].fl));
      $display("vec %0d: vld=%b fl=%b ready=%b mv=%b rsp=%b data=%0d busy=%b err=%b",
               i, req_vld, flush, req_ready, mul_vld, rsp_vld, rsp_data, busy, err);
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // Result valid during flush must not set err.
    do_reset();
    flush = 1'b1; force_vld = 1'b1;
    @(negedge clk);
    chk("flushvld.rsp", 32'(rsp_vld), 32'd0);
    $display("flush+res_vld: clear=%b rsp=%b", mul_clear, rsp_vld);
    @(posedge clk); #1;
    flush = 1'b0; force_vld = 1'b0;
    @(negedge clk);
    chk("flushvld.err", 32'(err), 32'd0);
    $display("after flush+res_vld: err=%b", err);

    // Mismatch: result valid with nothing in flight.
    @(posedge clk); #1;
    force_vld = 1'b1;
    @(negedge clk);
    chk("mism.rsp",  32'(rsp_vld),  32'd0);
    chk("mism.data", rsp_data,      32'd0);
    chk("mism.err0", 32'(err),      32'd0);
    $display("mismatch cycle: rsp=%b err=%b", rsp_vld, err);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      force_vld = 1'b0;
      @(negedge clk);
      chk($sformatf("mism.err%0d", c + 1), 32'(err), 32'd1);
      $display("mismatch +%0d: err=%b", c + 1, err);
    end

    // Async reset with two ops in flight.
    do_reset();
    req_vld = 4'b0011; req_a = pk(2, 3, 0, 0); req_b = pk(2, 3, 0, 0);
    @(negedge clk);
    chk("arst.ready0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst.ready1", 32'(req_ready), 32'b0010);
    chk("arst.busy1",  32'(busy),      32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy",   32'(busy),      32'd0);
    chk("arst.ready",  32'(req_ready), 32'd0);
    chk("arst.rsp",    32'(rsp_vld),   32'd0);
    chk("arst.mulvld", 32'(mul_vld),   32'd0);
    chk("arst.err",    32'(err),       32'd0);
    $display("async rst: busy=%b ready=%b rsp=%b", busy, req_ready, rsp_vld);
    rst = 1'b0;
    #1;
    chk("arst.first", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst.second", 32'(req_ready), 32'b0010);
    chk("arst.rsp_a",  32'(rsp_vld),   32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst.rsp_b",  32'(rsp_vld),   32'b0001);
    chk("arst.data",   rsp_data,       32'd4);
    $display("after rst: rsp=%b data=%0d", rsp_vld, rsp_data);
    req_vld = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
